// File: rtl/piano_engine.sv
// Purpose: key-priority lesson mode, per-note square-wave tone and a ROM-driven song sequencer.
// Latency: note follows keys after 1 cycle; a ROM word reaches note 2 cycles after its fetch starts.
// Backpressure: none; start is ignored while busy, stop aborts within one cycle.
module piano_engine #(
  parameter int NUM_KEYS  = 8,
  parameter logic [24*NUM_KEYS-1:0] NOTE_HP = {24'd95557, 24'd101239, 24'd113636, 24'd127551,
                                               24'd143172, 24'd151685, 24'd170265, 24'd191113},
  parameter int BEAT_DIV  = 6250000,
  parameter int GAP_CYC   = 500000,
  parameter int NUM_SONGS = 2,
  parameter int SONG_LEN  = 32,
  parameter int ROM_AW    = 6,
  localparam int SEL_W    = (NUM_SONGS > 1) ? $clog2(NUM_SONGS) : 1
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [NUM_KEYS-1:0] keys,
  input  logic                start,
  input  logic                stop,
  input  logic [SEL_W-1:0]    song_sel,
  input  logic                loop_en,
  output logic [ROM_AW-1:0]   rom_addr,
  input  logic [7:0]          rom_data,
  output logic                freq_out,
  output logic [3:0]          note,
  output logic [NUM_KEYS-1:0] led,
  output logic                busy
);

  localparam int IDX_W   = (SONG_LEN > 1) ? $clog2(SONG_LEN) : 1;
  localparam int CNT_MAX = (15 * BEAT_DIV > GAP_CYC) ? 15 * BEAT_DIV : GAP_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [SEL_W:0] SONGS_L = (SEL_W+1)'(NUM_SONGS);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_PLAY, S_GAP} state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   idx, idx_nxt;
  logic [ROM_AW-1:0]  base, base_nxt, addr_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [CNT_W-1:0]   play_last, play_last_nxt;
  logic [3:0]         note_nxt, key_note;
  logic [3:0]         rom_note, rom_dur;
  logic               sel_ok, advance, song_end;
  logic [23:0]        hp_sel, tcnt;

  assign rom_note = rom_data[7:4];
  assign rom_dur  = rom_data[3:0];
  assign sel_ok   = {1'b0, song_sel} < SONGS_L;
  assign busy     = (state != S_IDLE);

  // Lesson priority: the highest key bit maps to note 1 and wins over lower bits.
  always_comb begin
    key_note = '0;
    for (int k = NUM_KEYS; k >= 1; k--) begin
      if (keys[NUM_KEYS-k]) key_note = 4'(k);
    end
  end

  // LED one-hot and half-period lookup for the note currently sounding.
  always_comb begin
    led    = '0;
    hp_sel = '0;
    for (int k = 1; k <= NUM_KEYS; k++) begin
      if (note == 4'(k)) begin
        led[NUM_KEYS-k] = 1'b1;
        hp_sel          = NOTE_HP[24*(k-1) +: 24];
      end
    end
  end

  // Sequencer next-state: fetch, wait for ROM data, play, gap; stop overrides everything.
  always_comb begin
    state_nxt     = state;
    idx_nxt       = idx;
    base_nxt      = base;
    cnt_nxt       = cnt;
    play_last_nxt = play_last;
    note_nxt      = note;
    advance       = 1'b0;
    song_end      = 1'b0;
    case (state)
      S_IDLE: begin
        note_nxt = key_note;
        if (start && !stop && sel_ok) begin
          state_nxt = S_FETCH;
          base_nxt  = ROM_AW'(song_sel) * ROM_AW'(SONG_LEN);
          idx_nxt   = '0;
          note_nxt  = '0;
        end
      end
      S_FETCH: state_nxt = S_WAIT;
      S_WAIT: begin
        if (rom_dur == 4'd0 || rom_note > 4'(NUM_KEYS)) begin
          song_end = 1'b1;
        end else begin
          state_nxt     = S_PLAY;
          note_nxt      = rom_note;
          cnt_nxt       = '0;
          play_last_nxt = CNT_W'(rom_dur) * CNT_W'(BEAT_DIV) - CNT_W'(1);
        end
      end
      S_PLAY: begin
        if (cnt == play_last) begin
          note_nxt = '0;
          cnt_nxt  = '0;
          if (GAP_CYC == 0) advance = 1'b1;
          else              state_nxt = S_GAP;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      S_GAP: begin
        if (cnt == CNT_W'(GAP_CYC - 1)) begin
          cnt_nxt = '0;
          advance = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    // The last slot word ends the song even without an end marker.
    if (advance) begin
      if (idx == IDX_W'(SONG_LEN - 1)) begin
        song_end = 1'b1;
      end else begin
        idx_nxt   = idx + IDX_W'(1);
        state_nxt = S_FETCH;
      end
    end

    if (song_end) begin
      note_nxt = '0;
      if (loop_en) begin
        idx_nxt   = '0;
        state_nxt = S_FETCH;
      end else begin
        state_nxt = S_IDLE;
      end
    end

    if (stop && state != S_IDLE) begin
      state_nxt = S_IDLE;
      note_nxt  = '0;
    end

    // Address is presented during FETCH so the ROM word lands in WAIT.
    addr_nxt = rom_addr;
    if (state_nxt == S_FETCH) addr_nxt = base_nxt + ROM_AW'(idx_nxt);
  end

  // FSM state register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Sequencer datapath registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      idx       <= '0;
      base      <= '0;
      rom_addr  <= '0;
      cnt       <= '0;
      play_last <= '0;
      note      <= '0;
    end else begin
      idx       <= idx_nxt;
      base      <= base_nxt;
      rom_addr  <= addr_nxt;
      cnt       <= cnt_nxt;
      play_last <= play_last_nxt;
      note      <= note_nxt;
    end
  end

  // Tone generator: a note change restarts with a full low half-period.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      tcnt     <= '0;
      freq_out <= 1'b0;
    end else if (note_nxt != note || note_nxt == 4'd0) begin
      tcnt     <= '0;
      freq_out <= 1'b0;
    end else if (tcnt == hp_sel - 24'd1) begin
      tcnt     <= '0;
      freq_out <= ~freq_out;
    end else begin
      tcnt <= tcnt + 24'd1;
    end
  end

endmodule

// File: tb/tb_piano_engine.sv
// Directed bench for piano_engine: lesson mode, sequencing, looping, stop, async reset.
// Small parameters (BEAT_DIV=4, GAP_CYC=2, HP=k+1) keep every expectation hand-countable.
// Outputs are sampled on the falling edge; inputs change there too.
module tb_piano_engine;
  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic [7:0] keys = '0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [0:0] song_sel = '0;
  logic       loop_en = 1'b0;
  logic [5:0] rom_addr;
  logic [7:0] rom_data = '0;
  logic       freq_out;
  logic [3:0] note;
  logic [7:0] led;
  logic       busy;

  logic [7:0] rom [0:63];
  int         n_tests = 0;
  int         n_fail = 0;
  logic [3:0] ntrace[$];
  logic [5:0] atrace[$];
  int         busy_cnt;
  logic [7:0] fpat;
  logic [7:0] max_addr;

  piano_engine #(
    .NUM_KEYS(8),
    .NOTE_HP({24'd9, 24'd8, 24'd7, 24'd6, 24'd5, 24'd4, 24'd3, 24'd2}),
    .BEAT_DIV(4),
    .GAP_CYC(2),
    .NUM_SONGS(2),
    .SONG_LEN(4),
    .ROM_AW(6)
  ) dut (
    .CLK(CLK), .RESET(RESET), .keys(keys), .start(start), .stop(stop),
    .song_sel(song_sel), .loop_en(loop_en), .rom_addr(rom_addr), .rom_data(rom_data),
    .freq_out(freq_out), .note(note), .led(led), .busy(busy)
  );

  always #5 CLK = ~CLK;

  // Synchronous song ROM: data valid one cycle after the address.
  always @(posedge CLK) rom_data <= rom[rom_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic load_rom(input int b, input logic [7:0] w0, w1, w2, w3);
    rom[b] = w0; rom[b+1] = w1; rom[b+2] = w2; rom[b+3] = w3;
  endtask

  task automatic pulse_start(input logic [0:0] sel);
    song_sel = sel;
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
  endtask

  // Record note and fetched addresses each cycle while busy; optionally pulse start at cycle inj_at.
  task automatic trace_song(input int max_cyc, input int inj_at);
    logic [7:0] last;
    ntrace.delete();
    atrace.delete();
    busy_cnt = 0;
    max_addr = '0;
    last = 8'hFF;
    while (busy && busy_cnt < max_cyc) begin
      ntrace.push_back(note);
      if ({2'b00, rom_addr} != last) begin
        atrace.push_back(rom_addr);
        last = {2'b00, rom_addr};
      end
      if ({2'b00, rom_addr} > max_addr) max_addr = {2'b00, rom_addr};
      start = (busy_cnt == inj_at);
      busy_cnt++;
      @(negedge CLK);
    end
    start = 1'b0;
  endtask

  function automatic int count_note(input logic [3:0] v);
    int c = 0;
    foreach (ntrace[i]) if (ntrace[i] == v) c++;
    return c;
  endfunction

  function automatic int bursts(input logic [3:0] v);
    int c = 0;
    foreach (ntrace[i]) if (ntrace[i] == v && (i == 0 || ntrace[i-1] != v)) c++;
    return c;
  endfunction

  function automatic int first_idx(input logic [3:0] v);
    foreach (ntrace[i]) if (ntrace[i] == v) return i;
    return -1;
  endfunction

  function automatic logic [7:0] addr_at(input int i);
    if (i < atrace.size()) return {2'b00, atrace[i]};
    return 8'hFF;
  endfunction

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = 8'h00;

    // Reset state
    repeat (3) @(negedge CLK);
    check("rst_note", note, 0);
    check("rst_freq", freq_out, 0);
    check("rst_led", led, 0);
    check("rst_busy", busy, 0);
    check("rst_addr", rom_addr, 0);
    RESET = 1'b0;
    @(negedge CLK);

    // Lesson mode priority and tone
    keys = 8'b1000_0001;
    @(negedge CLK);
    check("key_note1", note, 1);
    check("key_led1", led, 8'b1000_0000);
    fpat[0] = freq_out;
    for (int i = 1; i < 8; i++) begin
      @(negedge CLK);
      fpat[i] = freq_out;
    end
    check("key_freq_pat", fpat, 8'hCC);
    keys = 8'h00;
    @(negedge CLK);
    check("key_off_note", note, 0);
    check("key_off_freq", freq_out, 0);
    check("key_off_led", led, 0);
    keys = 8'h01;
    @(negedge CLK);
    check("key_note8", note, 8);
    check("key_led8", led, 8'h01);
    keys = 8'h06;
    @(negedge CLK);
    check("key_note6", note, 6);
    check("key_led6", led, 8'h04);
    keys = 8'h00;
    repeat (2) @(negedge CLK);

    // Song 0: note, rest, end marker
    load_rom(0, 8'h32, 8'h01, 8'h00, 8'h00);
    loop_en = 1'b0;
    pulse_start(1'b0);
    trace_song(100, -1);
    check("s0_busy_cyc", busy_cnt, 22);
    check("s0_note3_cyc", count_note(3), 8);
    check("s0_zero_cyc", count_note(0), 14);
    check("s0_note3_first", first_idx(3), 2);
    check("s0_naddr", atrace.size(), 3);
    check("s0_addr0", addr_at(0), 0);
    check("s0_addr1", addr_at(1), 1);
    check("s0_addr2", addr_at(2), 2);
    check("s0_end_note", note, 0);

    // Song 1: full slot, no end marker, keys held but ignored
    load_rom(4, 8'h51, 8'h51, 8'h51, 8'h51);
    keys = 8'h01;
    @(negedge CLK);
    pulse_start(1'b1);
    trace_song(100, -1);
    check("s1_busy_cyc", busy_cnt, 32);
    check("s1_note5_cyc", count_note(5), 16);
    check("s1_bursts", bursts(5), 4);
    check("s1_keys_ignored", count_note(8), 0);
    check("s1_naddr", atrace.size(), 4);
    check("s1_addr_first", addr_at(0), 4);
    check("s1_addr_last", addr_at(3), 7);
    check("s1_max_addr", max_addr, 7);
    keys = 8'h00;
    repeat (2) @(negedge CLK);

    // Looping song 1, then stop mid-PLAY
    loop_en = 1'b1;
    pulse_start(1'b1);
    trace_song(40, -1);
    check("loop_busy", busy, 1);
    check("loop_naddr", atrace.size(), 5);
    check("loop_restart_addr", addr_at(4), 4);
    for (int i = 0; i < 20 && note !== 4'd5; i++) @(negedge CLK);
    check("loop_play_note", note, 5);
    @(negedge CLK);
    stop = 1'b1;
    @(negedge CLK);
    stop = 1'b0;
    check("stop_note", note, 0);
    check("stop_freq", freq_out, 0);
    check("stop_busy", busy, 0);
    loop_en = 1'b0;

    // start and stop together from IDLE; start while busy
    song_sel = 1'b0;
    start = 1'b1;
    stop = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    stop = 1'b0;
    check("ss_idle_busy", busy, 0);
    @(negedge CLK);
    check("ss_idle_busy2", busy, 0);
    pulse_start(1'b0);
    song_sel = 1'b1;
    trace_song(100, 5);
    check("busy_start_cyc", busy_cnt, 22);
    check("busy_start_note3", count_note(3), 8);
    check("busy_start_naddr", atrace.size(), 3);
    check("busy_start_addr2", addr_at(2), 2);

    // Asynchronous reset mid-PLAY with freq_out high
    load_rom(4, 8'h12, 8'h00, 8'h00, 8'h00);
    pulse_start(1'b1);
    for (int i = 0; i < 20 && freq_out !== 1'b1; i++) @(negedge CLK);
    check("arst_pre_freq", freq_out, 1);
    check("arst_pre_note", note, 1);
    check("arst_pre_addr", rom_addr, 4);
    #2 RESET = 1'b1;
    #1;
    check("arst_freq", freq_out, 0);
    check("arst_note", note, 0);
    check("arst_busy", busy, 0);
    check("arst_addr", rom_addr, 0);
    @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);

    // Note code above NUM_KEYS ends the song
    load_rom(0, 8'h93, 8'h32, 8'h00, 8'h00);
    pulse_start(1'b0);
    trace_song(20, -1);
    check("bad_note_busy_cyc", busy_cnt, 2);
    check("bad_note_no_play", count_note(3), 0);
    check("bad_note_naddr", atrace.size(), 1);
    check("bad_note_idle", busy, 0);
    check("bad_note_note", note, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
